shift_reg_univ: RTL and testbench

- Parametrised universal shift register; successor to the fixed 8-bit left-shift register.
- Supports WIDTH-bit left/right shift, rotate, parallel load, clear and hold, with a clock enable.
- A shift counter flags each completed frame of WIDTH serial shifts.
- Used as the serial/parallel converter in serial-link and LED/display datapaths.

---
 rtl/shift_reg_univ.sv | 118 +++++++++++
 tb/tb_shift_reg_univ.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_univ
// Description : Universal WIDTH-bit shift register (shift/rotate/load/clear)
//               with a frame counter flagging every WIDTH completed shifts.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module shift_reg_univ #(
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic [2:0]               i_mode,
    input  logic                     i_d,
    input  logic [WIDTH-1:0]         i_load_data,
    output logic                     o_q,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(WIDTH)-1:0] o_cnt,
    output logic                     o_frame_done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] C_MODE_HOLD  = 3'd0;
    localparam logic [2:0] C_MODE_SHL   = 3'd1;
    localparam logic [2:0] C_MODE_SHR   = 3'd2;
    localparam logic [2:0] C_MODE_ROL   = 3'd3;
    localparam logic [2:0] C_MODE_ROR   = 3'd4;
    localparam logic [2:0] C_MODE_LOAD  = 3'd5;
    localparam logic [2:0] C_MODE_CLEAR = 3'd6;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_data_q, w_data_d;
    logic             r_dir_q, w_dir_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic             r_frame_done_q, w_frame_done_d;
    logic             w_shift;

    always_comb begin
        w_data_d       = r_data_q;
        w_dir_d        = r_dir_q;
        w_cnt_d        = r_cnt_q;
        w_shift        = 1'b0;
        w_frame_done_d = 1'b0;

        // Mode is decoded only on enabled cycles so an unknown i_mode is harmless while idle
        if (i_en) begin
            case (i_mode)
                C_MODE_SHL: begin
                    w_data_d = {r_data_q[WIDTH-2:0], i_d};
                    w_dir_d  = 1'b0;
                    w_shift  = 1'b1;
                end
                C_MODE_SHR: begin
                    w_data_d = {i_d, r_data_q[WIDTH-1:1]};
                    w_dir_d  = 1'b1;
                    w_shift  = 1'b1;
                end
                C_MODE_ROL: begin
                    w_data_d = {r_data_q[WIDTH-2:0], r_data_q[WIDTH-1]};
                    w_dir_d  = 1'b0;
                    w_shift  = 1'b1;
                end
                C_MODE_ROR: begin
                    w_data_d = {r_data_q[0], r_data_q[WIDTH-1:1]};
                    w_dir_d  = 1'b1;
                    w_shift  = 1'b1;
                end
                C_MODE_LOAD: begin
                    w_data_d = i_load_data;
                    w_cnt_d  = '0;
                end
                C_MODE_CLEAR: begin
                    w_data_d = '0;
                    w_cnt_d  = '0;
                end
                default: ;  // hold and reserved encoding
            endcase
        end

        // Direction changes do not restart the frame; every shift counts
        if (w_shift) begin
            if (r_cnt_q == C_CNT_LAST) begin
                w_cnt_d        = '0;
                w_frame_done_d = 1'b1;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data_q       <= '0;
            r_dir_q        <= 1'b0;
            r_cnt_q        <= '0;
            r_frame_done_q <= 1'b0;
        end else begin
            r_data_q       <= w_data_d;
            r_dir_q        <= w_dir_d;
            r_cnt_q        <= w_cnt_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

    assign o_q          = r_dir_q ? r_data_q[0] : r_data_q[WIDTH-1];
    assign o_data       = r_data_q;
    assign o_cnt        = r_cnt_q;
    assign o_frame_done = r_frame_done_q;

    // Unused mode constant kept for readability of the decode table
    logic w_unused;
    assign w_unused = ^C_MODE_HOLD;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_reg_univ
// Description : Bench for shift_reg_univ at WIDTH=8 and WIDTH=16 against a
//               bit-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_univ;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        d   = 1'b0;
    logic [15:0] ld  = 16'd0;

    logic        q8, fd8, q16, fd16;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic [2:0]  cnt8;
    logic [3:0]  cnt16;

    int total = 0;
    int bad   = 0;
    int p8    = 0;
    int p16   = 0;

    // Reference state per instance: index 0 is WIDTH=8, index 1 is WIDTH=16
    logic [31:0] m_data [2];
    logic        m_dir  [2];
    int          m_cnt  [2];
    logic        m_fd   [2];
    int          m_w    [2] = '{8, 16};

    shift_reg_univ #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d),
        .i_load_data(ld[7:0]), .o_q(q8), .o_data(data8), .o_cnt(cnt8),
        .o_frame_done(fd8)
    );

    shift_reg_univ #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d),
        .i_load_data(ld), .o_q(q16), .o_data(data16), .o_cnt(cnt16),
        .o_frame_done(fd16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 32'd0;
            m_dir[i]  = 1'b0;
            m_cnt[i]  = 0;
            m_fd[i]   = 1'b0;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            int  w;
            bit  shifted;
            w       = m_w[i];
            shifted = 1'b0;
            m_fd[i] = 1'b0;
            if (en) begin
                case (mode)
                    3'd1: begin m_data[i] = ((m_data[i] << 1) | 32'(d)) & mask(w); m_dir[i] = 1'b0; shifted = 1'b1; end
                    3'd2: begin m_data[i] = (m_data[i] >> 1) | (32'(d) << (w - 1)); m_dir[i] = 1'b1; shifted = 1'b1; end
                    3'd3: begin m_data[i] = ((m_data[i] << 1) | (m_data[i] >> (w - 1))) & mask(w); m_dir[i] = 1'b0; shifted = 1'b1; end
                    3'd4: begin m_data[i] = (m_data[i] >> 1) | ((m_data[i] & 32'd1) << (w - 1)); m_dir[i] = 1'b1; shifted = 1'b1; end
                    3'd5: begin m_data[i] = 32'(ld) & mask(w); m_cnt[i] = 0; end
                    3'd6: begin m_data[i] = 32'd0; m_cnt[i] = 0; end
                    default: ;
                endcase
                if (shifted) begin
                    m_fd[i]  = (m_cnt[i] == w - 1);
                    m_cnt[i] = (m_cnt[i] + 1) % w;
                end
            end
        end
    endtask

    function automatic logic model_q(input int i);
        return m_dir[i] ? m_data[i][0] : m_data[i][m_w[i] - 1];
    endfunction

    task automatic compare_all();
        chk("data8",  32'(data8),  m_data[0]);
        chk("q8",     32'(q8),     32'(model_q(0)));
        chk("cnt8",   32'(cnt8),   32'(m_cnt[0]));
        chk("fd8",    32'(fd8),    32'(m_fd[0]));
        chk("data16", 32'(data16), m_data[1]);
        chk("q16",    32'(q16),    32'(model_q(1)));
        chk("cnt16",  32'(cnt16),  32'(m_cnt[1]));
        chk("fd16",   32'(fd16),   32'(m_fd[1]));
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic di, input logic [15:0] l);
        en = e; mode = m; d = di; ld = l;
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
        if (fd8)  p8++;
        if (fd16) p16++;
    endtask

    // Called 1 time unit after an edge: asserts reset well before the next edge
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #2;
        rst = 1'b0;
        p8  = 0;
        p16 = 0;
    endtask

    initial begin
        logic [7:0] bits_b2;
        logic [7:0] v96;
        bits_b2 = 8'b1011_0010;
        v96     = 8'h96;

        model_reset();
        #12;
        compare_all();
        rst = 1'b0;

        // Build A5 with cnt=3, then reset asynchronously mid-cycle
        step(1, 3'd5, 0, 16'h0014);
        step(1, 3'd1, 1, 16'h0);
        step(1, 3'd1, 0, 16'h0);
        step(1, 3'd1, 1, 16'h0);
        chk("pre_rst_data", 32'(data8), 32'hA5);
        chk("pre_rst_cnt",  32'(cnt8),  32'd3);
        mid_reset();
        chk("rst_data", 32'(data8), 32'h0);
        chk("rst_q",    32'(q8),    32'h0);

        // Serial in, MSB first
        for (int i = 7; i >= 0; i--) step(1, 3'd1, bits_b2[i], 16'h0);
        chk("sin_data", 32'(data8), 32'hB2);
        chk("sin_fd",   32'(fd8),   32'd1);
        chk("sin_cnt",  32'(cnt8),  32'd0);

        // Parallel in, serial out LSB first (right shift sets direction first)
        step(1, 3'd2, 0, 16'h0);
        step(1, 3'd5, 0, 16'h0096);
        p8 = 0;
        for (int i = 0; i < 8; i++) begin
            chk("piso_q", 32'(q8), 32'(v96[i]));
            step(1, 3'd2, 0, 16'h0);
        end
        chk("piso_data",   32'(data8), 32'h0);
        chk("piso_pulses", 32'(p8),    32'd1);

        // Rotate keeps every bit
        step(1, 3'd5, 0, 16'h0081);
        step(1, 3'd3, 0, 16'h0);
        chk("rol_data", 32'(data8), 32'h03);
        step(1, 3'd4, 0, 16'h0);
        step(1, 3'd4, 0, 16'h0);
        chk("ror_data", 32'(data8), 32'hC0);
        chk("ror_cnt",  32'(cnt8),  32'd3);

        // Enable gating with an unknown mode while disabled, then reserved mode
        mid_reset();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) step(1, 3'd1, 1'(i / 2), 16'h0);
            else            step(0, 3'bxxx, 1, 16'hFFFF);
        end
        step(1, 3'd7, 1, 16'h0);
        chk("en_pulses", 32'(p8), 32'd1);

        // Load mid-frame restarts the frame
        for (int i = 0; i < 5; i++) step(1, 3'd1, 1, 16'h0);
        step(1, 3'd5, 0, 16'h003C);
        chk("ldmid_data", 32'(data8), 32'h3C);
        chk("ldmid_cnt",  32'(cnt8),  32'd0);
        p8 = 0;
        for (int i = 0; i < 8; i++) step(1, 3'd1, 0, 16'h0);
        chk("ldmid_pulses", 32'(p8), 32'd1);

        // Back-to-back frames at both widths
        mid_reset();
        for (int i = 0; i < 32; i++) step(1, 3'($urandom_range(1, 4)), 1'($urandom), 16'h0);
        chk("b2b_pulses8",  32'(p8),  32'd4);
        chk("b2b_pulses16", 32'(p16), 32'd2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic       e;
            logic [2:0] m;
            e = ($urandom_range(0, 4) != 0);
            m = 3'($urandom_range(0, 7));
            if (!e && ($urandom_range(0, 3) == 0)) m = 3'bxxx;
            step(e, m, 1'($urandom), 16'($urandom));
            if ($urandom_range(0, 63) == 0) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
